// File: rtl/decay_trace_scheduler_if.sv
// decay_trace_scheduler_if: event inputs plus trace/strobe/status outputs
// of the decay trace scheduler. The master side drives i_event; the slave
// side (the scheduler) drives everything else.
// Optional feature macro: DECAY_COALESCE_CNT_EN adds o_coalesce_cnt.
interface decay_trace_scheduler_if #(
  parameter int p_channels   = 4,
  parameter int p_ch_width   = 2,
  parameter int p_base_width = 6
`ifdef DECAY_COALESCE_CNT_EN
  , parameter int p_cnt_width = 8
`endif
);
  logic [p_channels-1:0]              i_event;
  logic [p_channels*p_base_width-1:0] o_trace;
  logic                               o_clr_vld;
  logic [p_ch_width-1:0]              o_clr_ch;
  logic                               o_busy;
  logic                               o_overrun;
`ifdef DECAY_COALESCE_CNT_EN
  logic [p_cnt_width-1:0]             o_coalesce_cnt;
`endif

  modport master (
    output i_event,
    input  o_trace, o_clr_vld, o_clr_ch, o_busy, o_overrun
`ifdef DECAY_COALESCE_CNT_EN
    , input o_coalesce_cnt
`endif
  );

  modport slave (
    input  i_event,
    output o_trace, o_clr_vld, o_clr_ch, o_busy, o_overrun
`ifdef DECAY_COALESCE_CNT_EN
    , output o_coalesce_cnt
`endif
  );
endinterface

// File: rtl/decay_trace_scheduler.sv
// decay_trace_scheduler: bank of linearly decaying event traces sharing one
// reload/decrement datapath. Each cycle either a pending event is granted
// (round-robin, trace reloaded to all-ones, clear strobe pulsed) or the decay
// sweep decrements one trace. Sweeps are launched by a free-running prescaler.
// Optional feature macro: DECAY_COALESCE_CNT_EN (saturating count of events
// that hit an already-pending, non-granted channel).
module decay_trace_scheduler #(
  parameter int p_channels   = 4,
  parameter int p_ch_width   = 2,
  parameter int p_base_width = 6,
  parameter int p_decay_div  = 8,
  parameter int p_cnt_width  = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  decay_trace_scheduler_if.slave bus
);
  localparam int PRE_W = (p_decay_div > 2) ? $clog2(p_decay_div) : 1;
  localparam logic [p_ch_width-1:0] LAST_CH  = p_ch_width'(p_channels - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(p_decay_div - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Reject parameter sets the datapath cannot represent.
  if (p_channels < 2 || p_channels > 16 || (1 << p_ch_width) < p_channels ||
      p_decay_div < 2 || p_base_width < 1 || p_cnt_width < 1) begin : g_bad_params
    $error("decay_trace_scheduler: invalid parameter combination");
  end

  logic [p_channels-1:0] pending_q, pending_d;
  logic [p_ch_width-1:0] rr_ptr_q, rr_ptr_d;
  logic [p_ch_width-1:0] sw_ptr_q, sw_ptr_d;
  logic [PRE_W-1:0]      presc_q;
  logic [0:0]            state_q, state_d;
  logic                  clr_vld_q, busy_q, overrun_q;
  logic [p_ch_width-1:0] clr_ch_q;

  logic                  grant_vld;
  logic [p_ch_width-1:0] grant_ch;
  logic [p_channels-1:0] grant_onehot;
  logic [p_ch_width:0]   cand;
  logic                  tick;
  logic                  sweep_dec;

  assign tick = (presc_q == PRE_LAST);

  // Round-robin arbiter: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int i = 0; i < p_channels; i++) begin
      cand = {1'b0, rr_ptr_q} + (p_ch_width+1)'(i);
      if (cand >= (p_ch_width+1)'(p_channels))
        cand = cand - (p_ch_width+1)'(p_channels);
      if (!grant_vld && pending_q[cand[p_ch_width-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = cand[p_ch_width-1:0];
      end
    end
    grant_onehot = grant_vld ? (p_channels'(1) << grant_ch) : '0;
    // A new event on the granted channel keeps it pending (set wins).
    pending_d    = (pending_q & ~grant_onehot) | bus.i_event;
    rr_ptr_d     = rr_ptr_q;
    if (grant_vld)
      rr_ptr_d = (grant_ch == LAST_CH) ? '0 : grant_ch + p_ch_width'(1);
  end

  // Sweep sequencer: a grant steals the shared datapath, so the sweep stalls.
  always_comb begin
    state_d   = state_q;
    sw_ptr_d  = sw_ptr_q;
    sweep_dec = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d  = ST_SWEEP;
          sw_ptr_d = '0;
        end
      end
      ST_SWEEP: begin
        if (!grant_vld) begin
          sweep_dec = 1'b1;
          if (sw_ptr_q == LAST_CH) begin
            state_d  = ST_IDLE;
            sw_ptr_d = '0;
          end else begin
            sw_ptr_d = sw_ptr_q + p_ch_width'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sw_ptr_d = '0;
      end
    endcase
  end

  // Control state, prescaler and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      sw_ptr_q  <= '0;
      presc_q   <= '0;
      state_q   <= ST_IDLE;
      clr_vld_q <= 1'b0;
      clr_ch_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      sw_ptr_q  <= sw_ptr_d;
      presc_q   <= tick ? '0 : presc_q + PRE_W'(1);
      state_q   <= state_d;
      clr_vld_q <= grant_vld;
      clr_ch_q  <= grant_vld ? grant_ch : '0;
      // Mirrors the next registered state so o_busy tracks state_q/pending_q.
      busy_q    <= (state_d == ST_SWEEP) | (|pending_d);
      // A tick during an active sweep is dropped and flagged until reset.
      overrun_q <= overrun_q | (tick && (state_q == ST_SWEEP));
    end
  end

  genvar gi;
  for (gi = 0; gi < p_channels; gi++) begin : g_ch
    logic [p_base_width-1:0] trace_q;
    // Grant reloads to all-ones; otherwise the sweep decrements, floored at 0.
    always_ff @(posedge i_clk) begin
      if (i_rst)
        trace_q <= '0;
      else if (grant_vld && grant_ch == p_ch_width'(gi))
        trace_q <= '1;
      else if (sweep_dec && sw_ptr_q == p_ch_width'(gi) && trace_q != '0)
        trace_q <= trace_q - p_base_width'(1);
    end
    assign bus.o_trace[gi*p_base_width +: p_base_width] = trace_q;
  end

  assign bus.o_clr_vld = clr_vld_q;
  assign bus.o_clr_ch  = clr_ch_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_overrun = overrun_q;

`ifdef DECAY_COALESCE_CNT_EN
  localparam int INC_W = $clog2(p_channels + 1);
  logic [INC_W-1:0]       coal_inc;
  logic [p_cnt_width:0]   coal_sum;
  logic [p_cnt_width-1:0] coal_cnt_q;

  // Count re-hits on pending channels that are not being served this cycle.
  always_comb begin
    coal_inc = '0;
    for (int i = 0; i < p_channels; i++)
      coal_inc = coal_inc + INC_W'(bus.i_event[i] & pending_q[i] & ~grant_onehot[i]);
    coal_sum = {1'b0, coal_cnt_q} + (p_cnt_width+1)'(coal_inc);
  end

  // Saturating coalesce counter.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      coal_cnt_q <= '0;
    else if (coal_sum[p_cnt_width])
      coal_cnt_q <= '1;
    else
      coal_cnt_q <= coal_sum[p_cnt_width-1:0];
  end

  assign bus.o_coalesce_cnt = coal_cnt_q;
`endif
endmodule

// File: tb/tb_decay_trace_scheduler.sv
// Directed bench for decay_trace_scheduler (default parameters). Inputs are
// driven 1 time unit after each rising edge and outputs are checked at the
// same point. Edge En below means the n-th rising edge after reset release;
// with p_decay_div=8 sweeps start at E8, E16, E24 and decrement channel 0..3
// on the following four free cycles.
module tb_decay_trace_scheduler;
  localparam int CH  = 4;
  localparam int CW  = 2;
  localparam int BW  = 6;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decay_trace_scheduler_if #(.p_channels(CH), .p_ch_width(CW), .p_base_width(BW)) bus ();

  decay_trace_scheduler #(
    .p_channels(CH), .p_ch_width(CW), .p_base_width(BW),
    .p_decay_div(DIV), .p_cnt_width(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  function automatic logic [31:0] pack(input int t0, input int t1, input int t2, input int t3);
    logic [BW-1:0] a, b, c, d;
    a = BW'(t0); b = BW'(t1); c = BW'(t2); d = BW'(t3);
    return 32'({d, c, b, a});
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_event = CH'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0;
    bus.i_event = '0;
  endtask

  initial begin
    bus.i_event = '0;

    // Reset state
    do_reset();
    check("rst_trace",   32'(bus.o_trace),   pack(0, 0, 0, 0));
    check("rst_clr_vld", 32'(bus.o_clr_vld), 0);
    check("rst_clr_ch",  32'(bus.o_clr_ch),  0);
    check("rst_overrun", 32'(bus.o_overrun), 0);
    check("rst_busy",    32'(bus.o_busy),    0);

    // Single event on channel 2, then three sweeps
    bus.i_event = 4'b0100;
    step(1);                                   // E1: pending
    check("single_busy_pend", 32'(bus.o_busy),    1);
    check("single_no_strobe", 32'(bus.o_clr_vld), 0);
    bus.i_event = '0;
    step(1);                                   // E2: granted
    check("single_clr_vld", 32'(bus.o_clr_vld), 1);
    check("single_clr_ch",  32'(bus.o_clr_ch),  2);
    check("single_trace",   32'(bus.o_trace),   pack(0, 0, 63, 0));
    step(8);                                   // E10: mid-sweep
    check("single_busy_sweep", 32'(bus.o_busy),  1);
    check("single_pre_dec",    32'(bus.o_trace), pack(0, 0, 63, 0));
    step(1);                                   // E11: ch2 decremented
    check("single_dec1", 32'(bus.o_trace), pack(0, 0, 62, 0));
    step(17);                                  // E28: end of third sweep
    check("single_dec3",    32'(bus.o_trace),   pack(0, 0, 60, 0));
    check("single_idle",    32'(bus.o_busy),    0);
    check("single_overrun", 32'(bus.o_overrun), 0);

    // Round-robin grants, then a sweep stalled by a burst
    do_reset();
    bus.i_event = 4'b1111;
    step(1);                                   // E1
    bus.i_event = '0;
    for (int i = 0; i < 4; i++) begin          // E2..E5
      step(1);
      check($sformatf("rr_vld%0d", i), 32'(bus.o_clr_vld), 1);
      check($sformatf("rr_ch%0d", i),  32'(bus.o_clr_ch),  32'(i));
    end
    check("rr_all_loaded", 32'(bus.o_trace), pack(63, 63, 63, 63));
    step(3);                                   // E8: sweep starts
    bus.i_event = 4'b1111;
    step(1);                                   // E9: ch0 decremented
    check("stall_dec0",  32'(bus.o_trace),   pack(62, 63, 63, 63));
    check("stall_nostb", 32'(bus.o_clr_vld), 0);
    bus.i_event = '0;
    for (int i = 0; i < 4; i++) begin          // E10..E13: sweep stalled
      step(1);
      check($sformatf("stall_vld%0d", i), 32'(bus.o_clr_vld), 1);
      check($sformatf("stall_ch%0d", i),  32'(bus.o_clr_ch),  32'(i));
    end
    check("stall_reloaded", 32'(bus.o_trace), pack(63, 63, 63, 63));
    step(1);                                   // E14: resumes at ch1
    check("resume_dec1",   32'(bus.o_trace),   pack(63, 62, 63, 63));
    check("resume_clr_ch", 32'(bus.o_clr_ch),  0);
    step(1);                                   // E15
    check("resume_dec2",   32'(bus.o_trace),   pack(63, 62, 62, 63));
    check("resume_no_ovr", 32'(bus.o_overrun), 0);
    step(1);                                   // E16: last decrement + tick in sweep
    check("resume_dec3",   32'(bus.o_trace),   pack(63, 62, 62, 62));
    check("resume_ovr",    32'(bus.o_overrun), 1);
    check("resume_idle",   32'(bus.o_busy),    0);

    // Starvation: continuous events for 20 cycles
    do_reset();
    bus.i_event = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 15) check("starve_no_ovr15", 32'(bus.o_overrun), 0);
      if (k == 16) begin
        check("starve_ovr16", 32'(bus.o_overrun), 1);
        check("starve_ch16",  32'(bus.o_clr_ch),  2);
      end
    end
    check("starve_traces", 32'(bus.o_trace), pack(63, 63, 63, 63));
    bus.i_event = '0;
    step(1);                                   // E21
    check("drain_ch21", 32'(bus.o_clr_ch), 3);
    step(3);                                   // E24
    check("drain_ch24", 32'(bus.o_clr_ch), 2);
    step(4);                                   // E28: stalled sweep completes
    check("drain_traces", 32'(bus.o_trace),   pack(62, 62, 62, 62));
    check("drain_sticky", 32'(bus.o_overrun), 1);
    check("drain_idle",   32'(bus.o_busy),    0);
    do_reset();
    check("ovr_cleared", 32'(bus.o_overrun), 0);

    // Event on channel 1 in the cycle it is granted
    bus.i_event = 4'b0010;
    step(1);                                   // E1
    step(1);                                   // E2: grant ch1, new event lands
    check("rehit_vld1", 32'(bus.o_clr_vld), 1);
    check("rehit_ch1",  32'(bus.o_clr_ch),  1);
    bus.i_event = '0;
    step(1);                                   // E3: granted again after wrap
    check("rehit_vld2", 32'(bus.o_clr_vld), 1);
    check("rehit_ch2",  32'(bus.o_clr_ch),  1);
    step(1);                                   // E4
    check("rehit_done_vld", 32'(bus.o_clr_vld), 0);
    check("rehit_done_ch",  32'(bus.o_clr_ch),  0);
    check("rehit_idle",     32'(bus.o_busy),    0);

`ifdef DECAY_COALESCE_CNT_EN
    // Coalescing: ch1 re-hit while pending, ch0 re-hit while granted
    do_reset();
    check("coal_rst", 32'(bus.o_coalesce_cnt), 0);
    bus.i_event = 4'b0011;
    step(1);                                   // E1
    check("coal_first", 32'(bus.o_coalesce_cnt), 0);
    step(1);                                   // E2
    bus.i_event = '0;
    check("coal_cnt", 32'(bus.o_coalesce_cnt), 1);
    step(1);                                   // E3
    check("coal_hold", 32'(bus.o_coalesce_cnt), 1);
    check("coal_ch",   32'(bus.o_clr_ch),       1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
